// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: program ROM port, redirect/halt
// controls and the IF/ID valid/ready output stream.
interface fetch_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] imem_address;
   logic [DATA_WIDTH-1:0] imem_instruction;
   logic                  redirect_valid;
   logic [DATA_WIDTH-1:0] redirect_pc;
   logic                  halt;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_instruction;
   logic [DATA_WIDTH-1:0] out_pc;
   logic [DATA_WIDTH-1:0] out_pc_plus4;
   logic                  fault;

   modport master (
      output imem_address,
      output out_valid,
      output out_instruction,
      output out_pc,
      output out_pc_plus4,
      output fault,
      input  imem_instruction,
      input  redirect_valid,
      input  redirect_pc,
      input  halt,
      input  out_ready
   );

   modport slave (
      input  imem_address,
      input  out_valid,
      input  out_instruction,
      input  out_pc,
      input  out_pc_plus4,
      input  fault,
      output imem_instruction,
      output redirect_valid,
      output redirect_pc,
      output halt,
      output out_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC owner with 2-entry skid buffer toward IF/ID.
// Optional ROM bounds check: define FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer #(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h00400000,
   parameter int                    MEMORY_DEPTH = 32
) (
   input logic clk,
   input logic reset,
   fetch_sequencer_if.master bus
);

   typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

   localparam int W = DATA_WIDTH;

   if (MEMORY_DEPTH < 1) begin : g_depth_check
      $error("MEMORY_DEPTH must be positive");
   end

   state_t         state;
   state_t         state_next;
   logic [W-1:0]   fetch_pc;
   logic [W-1:0]   instr0, instr1;
   logic [W-1:0]   pc0, pc1;
   logic [1:0]     count;
   logic           pop;
   logic           room;
   logic           can_fetch;
   logic           push;
   logic           fault_hit;
   logic           tail1;

   assign bus.imem_address = fetch_pc;
   assign bus.out_valid    = (count != 2'd0);
   assign pop              = bus.out_valid & bus.out_ready;
   assign room             = (count != 2'd2) | pop;
   assign can_fetch        = (state == RUN) & ~bus.redirect_valid
                           & ~bus.halt & room;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [W:0] LIMIT =
      {1'b0, RESET_PC} + (W+1)'(4 * MEMORY_DEPTH);
   logic in_range;
   assign in_range  = (fetch_pc >= RESET_PC)
                    & ({1'b0, fetch_pc} < LIMIT);
   assign fault_hit = can_fetch & ~in_range;
   assign bus.fault = (state == FAULT);
`else
   assign fault_hit = 1'b0;
   assign bus.fault = 1'b0;
`endif

   assign push  = can_fetch & ~fault_hit;
   // Tail slot for a push, after any same-cycle pop shifts.
   assign tail1 = (count == 2'd2) | ((count == 2'd1) & ~pop);

   assign bus.out_instruction = bus.out_valid ? instr0 : '0;
   assign bus.out_pc          = bus.out_valid ? pc0 : '0;
   assign bus.out_pc_plus4    = bus.out_pc + W'(4);

   // Run/halt/fault control; fault only leaves via reset.
   always_comb begin
      state_next = state;
      unique case (state)
         RUN: begin
            if (fault_hit)     state_next = FAULT;
            else if (bus.halt) state_next = HALTED;
         end
         HALTED: begin
            if (!bus.halt) state_next = RUN;
         end
         default: state_next = state;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // Fetch PC: redirect reloads word-aligned, push advances.
   always_ff @(posedge clk) begin
      if (reset)
         fetch_pc <= RESET_PC;
      else if (bus.redirect_valid)
         fetch_pc <= bus.redirect_pc & ~W'(3);
      else if (push)
         fetch_pc <= fetch_pc + W'(4);
   end

   // Occupancy; a redirect flushes everything.
   always_ff @(posedge clk) begin
      if (reset)
         count <= 2'd0;
      else if (bus.redirect_valid)
         count <= 2'd0;
      else
         count <= count + {1'b0, push} - {1'b0, pop};
   end

   // Entry storage: pop shifts head, push fills the tail.
   always_ff @(posedge clk) begin
      if (!reset && !bus.redirect_valid) begin
         if (pop) begin
            instr0 <= instr1;
            pc0    <= pc1;
         end
         if (push && tail1) begin
            instr1 <= bus.imem_instruction;
            pc1    <= fetch_pc;
         end else if (push) begin
            instr0 <= bus.imem_instruction;
            pc0    <= fetch_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stream, backpressure,
// redirect, halt, reset and bounds behaviour.
module tb_fetch_sequencer;

   localparam logic [31:0] BASE = 32'h00400000;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   fetch_sequencer_if #(.DATA_WIDTH(32)) bus ();

   fetch_sequencer #(
      .DATA_WIDTH(32),
      .RESET_PC(BASE),
      .MEMORY_DEPTH(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'hC0DE0000 ^ a;
   endfunction

   assign bus.imem_instruction = rom(bus.imem_address);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.halt = 1'b0;
      bus.out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h exp=0", bus.out_valid); end
      total++; if (bus.out_instruction !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", bus.out_instruction); end
      total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
      total++; if (bus.out_pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", bus.out_pc_plus4); end
      total++; if (bus.imem_address !== BASE) begin bad++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_address, BASE); end
      total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%h exp=0", bus.fault); end
   endtask

   task automatic test_stream();
      logic [31:0] p;
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         p = BASE + 32'(4 * i);
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%h exp=1", i, bus.out_valid); end
         total++; if (bus.out_pc !== p) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, bus.out_pc, p); end
         total++; if (bus.out_instruction !== rom(p)) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, bus.out_instruction, rom(p)); end
         if (i == 0) begin
            total++; if (bus.out_pc_plus4 !== 32'h00400004) begin bad++; $display("FAIL stream_pc4 got=%h exp=00400004", bus.out_pc_plus4); end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] p;
      do_reset();
      repeat (5) step();
      total++; if (bus.imem_address !== 32'h00400008) begin bad++; $display("FAIL bp_addr got=%h exp=00400008", bus.imem_address); end
      total++; if (bus.out_pc !== BASE) begin bad++; $display("FAIL bp_head got=%h exp=%h", bus.out_pc, BASE); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p = BASE + 32'(4 * i);
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%h exp=1", i, bus.out_valid); end
         total++; if (bus.out_pc !== p) begin bad++; $display("FAIL bp_pc%0d got=%h exp=%h", i, bus.out_pc, p); end
         total++; if (bus.out_instruction !== rom(p)) begin bad++; $display("FAIL bp_instr%0d got=%h exp=%h", i, bus.out_instruction, rom(p)); end
         step();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      repeat (3) step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0040001E;
      step();
      bus.redirect_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%h exp=0", bus.out_valid); end
      total++; if (bus.imem_address !== 32'h0040001C) begin bad++; $display("FAIL redir_addr got=%h exp=0040001c", bus.imem_address); end
      step();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%h exp=1", bus.out_valid); end
      total++; if (bus.out_pc !== 32'h0040001C) begin bad++; $display("FAIL redir_pc got=%h exp=0040001c", bus.out_pc); end
      total++; if (bus.out_instruction !== rom(32'h0040001C)) begin bad++; $display("FAIL redir_instr got=%h exp=%h", bus.out_instruction, rom(32'h0040001C)); end
   endtask

   task automatic test_halt();
      do_reset();
      bus.out_ready = 1'b1;
      step();
      step();
      total++; if (bus.out_pc !== 32'h00400004) begin bad++; $display("FAIL halt_pre got=%h exp=00400004", bus.out_pc); end
      bus.halt = 1'b1;
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL halt_drain got=%h exp=0", bus.out_valid); end
      step();
      total++; if (bus.imem_address !== 32'h00400008) begin bad++; $display("FAIL halt_hold got=%h exp=00400008", bus.imem_address); end
      step();
      bus.halt = 1'b0;
      total++; if (bus.imem_address !== 32'h00400008) begin bad++; $display("FAIL halt_hold2 got=%h exp=00400008", bus.imem_address); end
      step();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL halt_wake got=%h exp=0", bus.out_valid); end
      step();
      total++; if (bus.out_pc !== 32'h00400008 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL halt_resume got=%h/%h exp=00400008/1", bus.out_pc, bus.out_valid); end
      bus.halt = 1'b1;
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h00400040;
      step();
      bus.redirect_valid = 1'b0;
      total++; if (bus.imem_address !== 32'h00400040) begin bad++; $display("FAIL halt_redir got=%h exp=00400040", bus.imem_address); end
      step();
      total++; if (bus.out_valid !== 1'b0 || bus.imem_address !== 32'h00400040) begin bad++; $display("FAIL halt_nofetch got=%h/%h exp=0/00400040", bus.out_valid, bus.imem_address); end
      bus.halt = 1'b0;
      step();
      step();
      total++; if (bus.out_pc !== 32'h00400040 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL halt_redir_run got=%h/%h exp=00400040/1", bus.out_pc, bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      repeat (3) step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h00400100;
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.redirect_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%h exp=0", bus.out_valid); end
      total++; if (bus.imem_address !== BASE) begin bad++; $display("FAIL rmid_addr got=%h exp=%h", bus.imem_address, BASE); end
      step();
      total++; if (bus.out_pc !== BASE) begin bad++; $display("FAIL rmid_first got=%h exp=%h", bus.out_pc, BASE); end
   endtask

   task automatic test_bounds();
      do_reset();
      bus.out_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h00400080;
      step();
      bus.redirect_valid = 1'b0;
      total++; if (bus.imem_address !== 32'h00400080) begin bad++; $display("FAIL bnd_addr got=%h exp=00400080", bus.imem_address); end
      step();
`ifdef FETCH_BOUNDS_CHECK_EN
      total++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL bnd_fault got=%h/%h exp=1/0", bus.fault, bus.out_valid); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = BASE;
      step();
      bus.redirect_valid = 1'b0;
      step();
      total++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL bnd_sticky got=%h/%h exp=1/0", bus.fault, bus.out_valid); end
      do_reset();
      total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL bnd_clear got=%h exp=0", bus.fault); end
`else
      total++; if (bus.fault !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bnd_nofault got=%h/%h exp=0/1", bus.fault, bus.out_valid); end
      total++; if (bus.out_pc !== 32'h00400080) begin bad++; $display("FAIL bnd_pc got=%h exp=00400080", bus.out_pc); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFFFFFE;
      step();
      bus.redirect_valid = 1'b0;
      step();
      total++; if (bus.out_pc !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_pc got=%h exp=fffffffc", bus.out_pc); end
      total++; if (bus.out_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=0", bus.out_pc_plus4); end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_reset_mid();
      test_bounds();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the single-cycle-read program ROM. It owns the fetch PC and drives the ROM byte address. It captures each returned instruction, with its PC, into a 2-entry skid buffer toward the IF/ID stage using a valid/ready handshake. It also handles branch/jump redirects (flush plus PC reload) and a halt request.

Parameters:
RESET_PC, 32'h00400000, byte address of first fetch after reset (ROM base)
MEMORY_DEPTH, 32, ROM depth in words; used only by the optional bounds check
DATA_WIDTH, 32, address/instruction width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
imem_address  output  DATA_WIDTH  byte address to program ROM; equals fetch_pc
imem_instruction  input  DATA_WIDTH  combinational ROM read data for imem_address
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  DATA_WIDTH  redirect target byte address
halt  input  1  level request to stop fetching
out_valid  output  1  buffer head holds a valid instruction
out_ready  input  1  IF/ID accepts head this cycle
out_instruction  output  DATA_WIDTH  head instruction
out_pc  output  DATA_WIDTH  head PC
out_pc_plus4  output  DATA_WIDTH  head PC + 4, wraps mod 2^32
fault  output  1  sticky bounds fault (optional feature)

Behaviour:
- State: fetch_pc register, 2-entry FIFO (instr, pc), count in {0,1,2}, FSM {RUN, HALTED, FAULT}.
- Reset (clk edge with reset=1): fetch_pc=RESET_PC, count=0, state=RUN, fault=0. All outputs are then: out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=4, imem_address=RESET_PC. Reset mid-operation discards buffer contents and any pending redirect.
- imem_address = fetch_pc, combinational from the register.
- pop = out_valid & out_ready. out_valid = (count!=0).
- push = (state==RUN) & !redirect_valid & (count<2 | pop). On push: the FIFO tail captures {imem_instruction, fetch_pc}, and fetch_pc <= fetch_pc+4 (mod 2^32).
- Simultaneous push and pop at count=2 is legal; count stays 2 and order is preserved.
- Redirect has priority over push and pop. With redirect_valid=1:
  - count<=0, all entries discarded, no push.
  - fetch_pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are dropped.
  - A pop on the same cycle is still consumed by the downstream stage; the flush discards everything else.
- Redirect latency: redirect sampled in cycle N. Target appears on imem_address in N+1. out_valid=1 with the target instruction in N+2, provided halt=0.
- Steady-state throughput: one instruction per cycle when out_ready=1.
- FSM transitions:
  - RUN -> HALTED when halt=1 (no push that cycle).
  - HALTED -> RUN when halt=0.
  - In HALTED, buffered entries still drain via pop. A redirect in HALTED reloads fetch_pc and flushes, and the state stays HALTED.
  - FAULT is exited only by reset.
- out_pc_plus4 is computed from the head pc.

Optional Feature:
Macro FETCH_BOUNDS_CHECK_EN.
- Defined: the push condition additionally requires fetch_pc in [RESET_PC, RESET_PC+4*MEMORY_DEPTH).
  - If state==RUN and the push would otherwise occur with fetch_pc outside that range: no push, state<=FAULT, fault<=1.
  - fault is sticky until reset. Redirect and halt do not clear it, though a redirect still flushes the buffer.
  - Entries already buffered continue to drain.
- Undefined: fault is tied 0 and the FAULT state is unreachable. Out-of-range addresses are fetched unchecked.

Test Plan:
- Reset, then out_ready=1 for 4 cycles with ROM words 0..3 = A,B,C,D -> out_valid rises in cycle 1; outputs are (A,0x00400000), (B,0x00400004), (C,0x00400008) in consecutive cycles; out_pc_plus4=0x00400004 with A.
- Backpressure: out_ready=0 for 5 cycles -> count saturates at 2 and imem_address holds 0x00400008. Then out_ready=1 -> A,B,C,D in order, with no duplicates and no gaps.
- Redirect to 0x0040001E while count=2 -> buffer flushed next cycle and imem_address=0x0040001C. out_valid=1 with word 7 and out_pc=0x0040001C two cycles after the redirect.
- halt=1 for 3 cycles with 1 entry buffered and out_ready=1 -> the entry drains and imem_address stays constant. Deassert -> fetch resumes at the held PC. Redirect while halted -> PC reloads and no fetch occurs until halt=0.
- Reset asserted while count=2 and a redirect is pending -> next cycle out_valid=0 and imem_address=0x00400000.
- With FETCH_BOUNDS_CHECK_EN, MEMORY_DEPTH=32: redirect to 0x00400080 -> fault=1 one cycle later, out_valid stays 0, and a later redirect to 0x00400000 leaves fault=1 until reset. Without the macro: same stimulus fetches 0x00400080 and fault stays 0.
